// File: rtl/regfile_dumper_pkg.sv
// ============================================================================
// Module      : regfile_dumper_pkg
// Description : Shared FSM state encoding, default sizing and address width
//               for the register-file dumper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_dumper_pkg;

    localparam int NUM_REGS_DEF   = 32;
    localparam int WORD_BYTES_DEF = 4;
    localparam int ADDR_W         = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_SEND = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/regfile_dumper_word_serializer.sv
// ============================================================================
// Module      : word_serializer
// Description : Captures one 32-bit register word and presents it one byte
//               at a time, most significant byte first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_serializer
    import regfile_dumper_pkg::*;
#(
    parameter int WORD_BYTES = WORD_BYTES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        advance_i,
    input  logic [31:0] word_i,
    output logic [7:0]  byte_o,
    output logic        last_byte_o
);

    localparam int              CNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WORD_BYTES - 1);

    logic [31:0]      word_q;
    logic [CNT_W-1:0] cnt_q;

    // The word is shifted left on each accepted byte so the current byte is
    // always the top octet; the counter stops at the last byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            word_q <= word_i;
            cnt_q  <= '0;
        end else if (advance_i && (cnt_q != C_LAST)) begin
            word_q <= {word_q[23:0], 8'h00};
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign byte_o      = word_q[31:24];
    assign last_byte_o = (cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/regfile_dumper.sv
// ============================================================================
// Module      : regfile_dumper
// Description : Walks the register file on request and streams every word
//               out as bytes over a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_dumper
    import regfile_dumper_pkg::*;
#(
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int WORD_BYTES = WORD_BYTES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rs,
    input  logic [31:0]       readData1,
    output logic              stall_req,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last
);

    localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] rs_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;

    logic              ser_load;
    logic              ser_adv;
    logic              ser_last;
    logic [7:0]        ser_byte;

    assign ser_load = (state_q == ST_ADDR);
    assign ser_adv  = valid_q && out_ready;

    word_serializer #(
        .WORD_BYTES (WORD_BYTES)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .load_i      (ser_load),
        .advance_i   (ser_adv),
        .word_i      (readData1),
        .byte_o      (ser_byte),
        .last_byte_o (ser_last)
    );

    // Outputs are registered alongside the state so each one is a flop
    // that already holds the value belonging to the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rs_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= ST_ADDR;
                        idx_q   <= '0;
                        rs_q    <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    state_q <= ST_SEND;
                    rs_q    <= '0;
                    valid_q <= 1'b1;
                end
                ST_SEND: begin
                    if (out_ready && ser_last) begin
                        valid_q <= 1'b0;
                        if (idx_q == C_LAST_IDX) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ADDR;
                            idx_q   <= idx_q + 1'b1;
                            rs_q    <= idx_q + 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rs        = rs_q;
    assign busy      = busy_q;
    assign stall_req = busy_q;
    assign done      = done_q;
    assign out_valid = valid_q;
    assign out_data  = ser_byte;
    assign out_last  = valid_q && (idx_q == C_LAST_IDX) && ser_last;

endmodule

`default_nettype wire

// File: tb/tb_regfile_dumper.sv
// ============================================================================
// Module      : tb_regfile_dumper
// Description : Self-checking bench for regfile_dumper with a byte-stream
//               scoreboard built from the register contents at start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_dumper;

    localparam int NR = 32;
    localparam int WB = 4;
    localparam int NB = NR * WB;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  rs;
    logic [31:0] readData1;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;

    logic [31:0] regs [0:NR-1];

    int          errors = 0;
    int          checks = 0;
    logic [8:0]  exp_q [$];
    int          hs_cnt;
    int          got_n;
    int          done_cnt;
    logic [7:0]  got [0:NB-1];
    logic        got_last [0:NB-1];
    bit          have_hold;
    logic [7:0]  hold_data;
    logic        hold_last;
    int          rdy_mode = 0;

    always #5 clk = ~clk;

    assign readData1 = regs[rs];

    regfile_dumper #(
        .NUM_REGS   (NR),
        .WORD_BYTES (WB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rs        (rs),
        .readData1 (readData1),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected stream: every register, MSB byte first, last flag on the final byte.
    task automatic build_expect();
        logic [7:0] b8;
        exp_q.delete();
        for (int i = 0; i < NR; i++) begin
            for (int b = 0; b < WB; b++) begin
                b8 = 8'((regs[i] >> (8 * (WB - 1 - b))) & 32'hFF);
                exp_q.push_back({(i == NR - 1) && (b == WB - 1), b8});
            end
        end
        hs_cnt   = 0;
        got_n    = 0;
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        build_expect();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk("done_seen", done, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_addr(input int idx);
        int n;
        n = 0;
        while (!(busy && !out_valid && !done && rs == 5'(idx)) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("addr_reached", rs, idx);
    endtask

    task automatic randomize_regs();
        for (int i = 0; i < NR; i++) regs[i] = $urandom;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rs"}, rs, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_stall"}, stall_req, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard / protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            have_hold = 1'b0;
        end else begin
            chk("stall_tracks_busy", stall_req, busy);
            if (!busy) begin
                chk("idle_valid", out_valid, 0);
                chk("idle_rs", rs, 0);
                chk("idle_done", done, 0);
            end
            if (done) begin
                done_cnt++;
                chk("done_stream_complete", exp_q.size(), 0);
                chk("done_valid_low", out_valid, 0);
            end
            if (out_valid) begin
                chk("send_rs", rs, 0);
                if (exp_q.size() == 0) begin
                    chk("extra_byte", 1, 0);
                end else begin
                    chk("byte_data", out_data, exp_q[0][7:0]);
                    chk("byte_last", out_last, exp_q[0][8]);
                end
                if (have_hold) begin
                    chk("hold_data", out_data, hold_data);
                    chk("hold_last", out_last, hold_last);
                end
                if (out_ready) begin
                    if (got_n < NB) begin
                        got[got_n]      = out_data;
                        got_last[got_n] = out_last;
                    end
                    got_n++;
                    hs_cnt++;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    have_hold = 1'b0;
                end else begin
                    have_hold = 1'b1;
                    hold_data = out_data;
                    hold_last = out_last;
                end
            end else begin
                if (have_hold) chk("valid_dropped", out_valid, 1);
                have_hold = 1'b0;
                chk("last_low", out_last, 0);
                if (busy && !done) chk("addr_rs", rs, hs_cnt / WB);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int nl;
        logic [31:0] old5;

        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < NR; i++) regs[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Full dump, always ready, fixed pattern.
        for (int i = 0; i < NR; i++) regs[i] = 32'h11111111 * (i % 16);
        regs[31]  = 32'hDEADBEEF;
        out_ready = 1'b1;
        pulse_start();
        chk("lat_addr_busy", busy, 1);
        chk("lat_addr_valid", out_valid, 0);
        chk("lat_addr_rs", rs, 0);
        @(posedge clk); #1;
        chk("lat_first_valid", out_valid, 1);
        chk("lat_first_data", out_data, 8'h00);
        k = 1;
        while (!done && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        chk("done_cycle", k, 160);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("after_fin_done", done, 0);
        chk("after_fin_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("fin_start_ignored", busy, 0);
        chk("a_bytes", got_n, 128);
        chk("a_done_cnt", done_cnt, 1);
        for (int j = 4; j < 8; j++) chk("a_r1_byte", got[j], 8'h11);
        chk("a_r31_b0", got[124], 8'hDE);
        chk("a_r31_b1", got[125], 8'hAD);
        chk("a_r31_b2", got[126], 8'hBE);
        chk("a_r31_b3", got[127], 8'hEF);
        chk("a_last_on_ef", got_last[127], 1);
        nl = 0;
        for (int j = 0; j < NB; j++) nl += int'(got_last[j]);
        chk("a_last_count", nl, 1);

        // Back-pressure on byte 2 of R[0].
        randomize_regs();
        regs[0]   = 32'hA1B2C3D4;
        out_ready = 1'b0;
        pulse_start();
        @(posedge clk); #1;
        chk("b_byte0", out_data, 8'hA1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            chk("b_hold_data", out_data, 8'hB2);
            chk("b_hold_valid", out_valid, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk("b_hold_end", out_data, 8'hB2);
        @(posedge clk); #1;
        chk("b_resume", out_data, 8'hC3);
        rdy_mode = 1;
        wait_done(3000);
        chk("b_bytes", got_n, 128);
        chk("b_done_cnt", done_cnt, 1);

        // Restart attempt mid-dump under random ready.
        randomize_regs();
        pulse_start();
        k = 1;
        while (!done && k < 3000) begin
            start = (k == 50);
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        chk("c_done_seen", done, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("c_bytes", got_n, 128);
        chk("c_done_cnt", done_cnt, 1);
        chk("c_idle", busy, 0);

        // Write to R[5] just after it was captured.
        randomize_regs();
        old5 = regs[5];
        pulse_start();
        wait_addr(5);
        @(posedge clk); #1;
        regs[5] = ~old5;
        wait_done(3000);
        chk("d_r5_b0", got[20], old5[31:24]);
        chk("d_r5_b1", got[21], old5[23:16]);
        chk("d_r5_b2", got[22], old5[15:8]);
        chk("d_r5_b3", got[23], old5[7:0]);

        // Asynchronous reset while sending R[10].
        randomize_regs();
        pulse_start();
        wait_addr(10);
        @(posedge clk); #1;
        chk("e_in_send", out_valid, 1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk_reset_outputs("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("e_no_resume", busy, 0);
        pulse_start();
        chk("e_restart_rs", rs, 0);
        wait_done(3000);
        chk("e_r0_b0", got[0], regs[0][31:24]);
        chk("e_r0_b3", got[3], regs[0][7:0]);
        chk("e_bytes", got_n, 128);
        chk("e_done_cnt", done_cnt, 1);

        rdy_mode = 0;
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
